guess_checker: RTL and testbench



---
 rtl/hangman_pkg.sv | 33 +++
 rtl/guess_checker_slot_match.sv | 22 ++
 rtl/guess_checker.sv | 137 +++++++++++++
 tb/tb_guess_checker.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and state encodings for the hangman letter-guessing datapath
// and the game-state controller.
package hangman_pkg;

    localparam int LETTER_W = 5;
    localparam int N_SLOTS  = 6;
    localparam int ALPHA    = 26;
    localparam int WORD_W   = N_SLOTS * LETTER_W;

    localparam logic [LETTER_W-1:0] BLANK = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_GUESS,
        ST_CHECK,
        ST_EVAL,
        ST_WON,
        ST_LOST
    } checker_state_t;

    typedef enum logic [1:0] {
        START,
        INGAME,
        WINGAME,
        LOSTGAME
    } game_state_t;

    function automatic logic is_letter(input logic [LETTER_W-1:0] c);
        return c < LETTER_W'(ALPHA);
    endfunction

endpackage

// File: rtl/guess_checker_slot_match.sv
// slot_match: compares one letter code against every word slot and flags
// which slots hold that letter and which slots are blank.
module slot_match
    import hangman_pkg::*;
(
    input  logic [WORD_W-1:0]   i_word,
    input  logic [LETTER_W-1:0] i_letter,
    output logic [N_SLOTS-1:0]  o_hit,
    output logic [N_SLOTS-1:0]  o_blank
);

    // Slot 0 sits in the most significant letter field of the word.
    always_comb begin
        o_hit   = '0;
        o_blank = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            o_hit[i]   = (i_word[(N_SLOTS-1-i)*LETTER_W +: LETTER_W] == i_letter);
            o_blank[i] = (i_word[(N_SLOTS-1-i)*LETTER_W +: LETTER_W] == BLANK);
        end
    end

endmodule

// File: rtl/guess_checker.sv
// guess_checker: tracks revealed slots, guessed letters and wrong guesses for one
// hangman level. Define REPEAT_PENALTY_EN to count repeated guesses as wrong.
module guess_checker
    import hangman_pkg::*;
#(
    parameter int MAX_WRONG = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                new_game,
    input  logic                game_active,
    input  logic [WORD_W-1:0]   word,
    input  logic [ALPHA-1:0]    mask,
    input  logic                guess_valid,
    input  logic [LETTER_W-1:0] guess_letter,
    output logic                guess_ready,
    output logic [N_SLOTS-1:0]  revealed,
    output logic [ALPHA-1:0]    guessed,
    output logic [3:0]          wrong_count,
    output logic                win_game,
    output logic                lost_game
);

    localparam logic [3:0] MAX_W = 4'(MAX_WRONG);

`ifdef REPEAT_PENALTY_EN
    localparam logic REPEAT_PENALTY = 1'b1;
`else
    localparam logic REPEAT_PENALTY = 1'b0;
`endif

    checker_state_t      r_state;
    logic [WORD_W-1:0]   r_word;
    logic [ALPHA-1:0]    r_mask;
    logic [LETTER_W-1:0] r_letter;
    logic [N_SLOTS-1:0]  r_revealed;
    logic [ALPHA-1:0]    r_guessed;
    logic [3:0]          r_wrong;
    logic                r_win;
    logic                r_lost;

    logic [WORD_W-1:0]   w_match_word;
    logic [N_SLOTS-1:0]  w_hit;
    logic [N_SLOTS-1:0]  w_blank;
    logic                w_valid_letter;
    logic                w_repeat;
    logic                w_in_word;
    logic                w_wrong_guess;

    // During LOAD the word is still on the input port; afterwards use the stored copy.
    assign w_match_word = (r_state == ST_LOAD) ? word : r_word;

    slot_match u_slot_match (
        .i_word   (w_match_word),
        .i_letter (r_letter),
        .o_hit    (w_hit),
        .o_blank  (w_blank)
    );

    assign w_valid_letter = is_letter(r_letter);
    assign w_repeat       = w_valid_letter && r_guessed[r_letter];
    assign w_in_word      = w_valid_letter && r_mask[r_letter];
    assign w_wrong_guess  = w_valid_letter && (w_repeat ? REPEAT_PENALTY : !w_in_word);

    assign guess_ready = (r_state == ST_WAIT_GUESS) && game_active;
    assign revealed    = r_revealed;
    assign guessed     = r_guessed;
    assign wrong_count = r_wrong;
    assign win_game    = r_win;
    assign lost_game   = r_lost;

    // new_game overrides every state, including a guess offered in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_mask     <= '0;
            r_letter   <= '0;
            r_revealed <= '0;
            r_guessed  <= '0;
            r_wrong    <= '0;
            r_win      <= 1'b0;
            r_lost     <= 1'b0;
        end else if (new_game) begin
            r_state   <= ST_LOAD;
            r_guessed <= '0;
            r_wrong   <= '0;
            r_win     <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_word     <= word;
                    r_mask     <= mask;
                    r_revealed <= w_blank;
                    r_state    <= ST_WAIT_GUESS;
                end
                ST_WAIT_GUESS: begin
                    if (guess_valid && guess_ready) begin
                        r_letter <= guess_letter;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_valid_letter) begin
                        r_guessed[r_letter] <= 1'b1;
                    end
                    if (w_in_word && !w_repeat) begin
                        r_revealed <= r_revealed | w_hit;
                    end
                    if (w_wrong_guess && (r_wrong < MAX_W)) begin
                        r_wrong <= r_wrong + 4'd1;
                    end
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (&r_revealed) begin
                        r_win   <= 1'b1;
                        r_state <= ST_WON;
                    end else if (r_wrong == MAX_W) begin
                        r_lost  <= 1'b1;
                        r_state <= ST_LOST;
                    end else begin
                        r_state <= ST_WAIT_GUESS;
                    end
                end
                ST_IDLE, ST_WON, ST_LOST: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: directed scenarios plus random games,
// all checked against a set-based model of the hangman rules.
module tb_guess_checker;

   localparam int MAX_WRONG = 6;

`ifdef REPEAT_PENALTY_EN
   localparam bit PENALTY = 1'b1;
`else
   localparam bit PENALTY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        new_game = 1'b0;
   logic        game_active = 1'b0;
   logic [29:0] word = '0;
   logic [25:0] mask = '0;
   logic        guess_valid = 1'b0;
   logic [4:0]  guess_letter = '0;
   logic        guess_ready;
   logic [5:0]  revealed;
   logic [25:0] guessed;
   logic [3:0]  wrong_count;
   logic        win_game;
   logic        lost_game;

   int checks = 0;
   int errors = 0;

   logic [4:0]  mSlots [6];
   logic [25:0] mGuessed;
   int          mWrong;
   bit          mWin;
   bit          mLost;

   guess_checker #(.MAX_WRONG(MAX_WRONG)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .new_game     (new_game),
      .game_active  (game_active),
      .word         (word),
      .mask         (mask),
      .guess_valid  (guess_valid),
      .guess_letter (guess_letter),
      .guess_ready  (guess_ready),
      .revealed     (revealed),
      .guessed      (guessed),
      .wrong_count  (wrong_count),
      .win_game     (win_game),
      .lost_game    (lost_game)
   );

   always #5 clk = ~clk;

   // Model: a slot is visible when it is blank or its letter has been guessed.
   function automatic logic [5:0] expRevealed();
      logic [5:0] r = '0;
      for (int i = 0; i < 6; i++)
         r[i] = (mSlots[i] == 5'd31) || (mSlots[i] < 5'd26 && mGuessed[mSlots[i]]);
      return r;
   endfunction

   function automatic logic [25:0] maskOf();
      logic [25:0] m = '0;
      for (int i = 0; i < 6; i++)
         if (mSlots[i] < 5'd26) m[mSlots[i]] = 1'b1;
      return m;
   endfunction

   function automatic logic [38:0] expVec();
      return {expRevealed(), mGuessed, 4'(mWrong), mWin, mLost,
              game_active && !mWin && !mLost};
   endfunction

   function automatic logic [38:0] obsVec();
      return {revealed, guessed, wrong_count, win_game, lost_game, guess_ready};
   endfunction

   // Model update for one completed guess, written from the game rules.
   task automatic modelGuess(input logic [4:0] l);
      bit inWord = 1'b0;
      logic [5:0] r;
      if (l < 5'd26) begin
         if (mGuessed[l]) begin
            if (PENALTY && mWrong < MAX_WRONG) mWrong++;
         end else begin
            mGuessed[l] = 1'b1;
            for (int i = 0; i < 6; i++) if (mSlots[i] == l) inWord = 1'b1;
            if (!inWord && mWrong < MAX_WRONG) mWrong++;
         end
      end
      r = expRevealed();
      mWin  = &r;
      mLost = !mWin && (mWrong == MAX_WRONG);
   endtask

   task automatic resetModel(input logic [29:0] w);
      for (int i = 0; i < 6; i++) mSlots[i] = w[(5-i)*5 +: 5];
      mGuessed = '0;
      mWrong   = 0;
      mWin     = 1'b0;
      mLost    = 1'b0;
   endtask

   // Called #1 after an edge; returns #1 after the LOAD->WAIT_GUESS edge.
   task automatic applyNewGame(input logic [29:0] w);
      resetModel(w);
      word = w;
      mask = maskOf();
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      @(posedge clk); #1;
   endtask

   // Offers a guess for one edge, then waits out CHECK and EVAL while scrambling the word inputs.
   task automatic applyGuess(input logic [4:0] l);
      guess_valid = 1'b1;
      guess_letter = l;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      guess_letter = 5'($urandom);
      word = 30'($urandom);
      mask = 26'($urandom);
      repeat (2) @(posedge clk);
      #1;
      modelGuess(l);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      game_active = 1'b1;
      guess_valid = 1'b1;
      #12;
      checks++;
      if (obsVec() !== 39'd0) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h expected %h", obsVec(), 39'd0);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obsVec() !== 39'd0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got %h expected %h", obsVec(), 39'd0);
      end
      guess_valid = 1'b0;
   endtask

   task automatic test_hello();
      logic [4:0] seq [3] = '{5'd11, 5'd7, 5'd4};
      applyNewGame({5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd31});
      checks++;
      if (revealed !== 6'b100000 || guess_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hello_load: got revealed=%b ready=%b expected revealed=100000 ready=1",
                  revealed, guess_ready);
      end
      foreach (seq[i]) begin
         applyGuess(seq[i]);
         checks++;
         if (obsVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL hello_guess_%0d: got %h expected %h", seq[i], obsVec(), expVec());
         end
      end
      guess_valid = 1'b1;
      guess_letter = 5'd14;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (win_game !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hello_win_early: got win=%b expected win=0", win_game);
      end
      @(posedge clk); #1;
      modelGuess(5'd14);
      checks++;
      if (obsVec() !== expVec() || win_game !== 1'b1 || revealed !== 6'b111111) begin
         errors++;
         $display("[TB] FAIL hello_win: got %h expected %h", obsVec(), expVec());
      end
      guess_valid = 1'b1;
      guess_letter = 5'd25;
      repeat (4) @(posedge clk);
      #1;
      guess_valid = 1'b0;
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL hello_won_hold: got %h expected %h", obsVec(), expVec());
      end
   endtask

   task automatic test_loss();
      logic [4:0] seq [6] = '{5'd25, 5'd16, 5'd23, 5'd9, 5'd10, 5'd21};
      applyNewGame({5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd31});
      foreach (seq[i]) begin
         applyGuess(seq[i]);
         checks++;
         if (obsVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL loss_guess_%0d: got %h expected %h", i, obsVec(), expVec());
         end
      end
      checks++;
      if (lost_game !== 1'b1 || guess_ready !== 1'b0 || wrong_count !== 4'd6) begin
         errors++;
         $display("[TB] FAIL loss_final: got lost=%b ready=%b wrong=%0d expected lost=1 ready=0 wrong=6",
                  lost_game, guess_ready, wrong_count);
      end
   endtask

   task automatic test_repeat_and_invalid();
      applyNewGame({5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd31});
      applyGuess(5'd11);
      applyGuess(5'd11);
      checks++;
      if (obsVec() !== expVec() || wrong_count !== 4'(PENALTY)) begin
         errors++;
         $display("[TB] FAIL repeat_guess: got %h expected %h (wrong %0d vs %0d)",
                  obsVec(), expVec(), wrong_count, PENALTY);
      end
      applyGuess(5'd28);
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL invalid_letter: got %h expected %h", obsVec(), expVec());
      end
   endtask

   task automatic test_game_active();
      game_active = 1'b0;
      guess_valid = 1'b1;
      guess_letter = 5'd7;
      repeat (3) @(posedge clk);
      #1;
      guess_valid = 1'b0;
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL inactive_no_accept: got %h expected %h", obsVec(), expVec());
      end
      game_active = 1'b1;
      guess_valid = 1'b1;
      guess_letter = 5'd4;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      game_active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      modelGuess(5'd4);
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL inactive_mid_check: got %h expected %h", obsVec(), expVec());
      end
      game_active = 1'b1;
      #1;
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL reactivate_ready: got %h expected %h", obsVec(), expVec());
      end
   endtask

   task automatic test_reset_mid_check();
      guess_valid = 1'b1;
      guess_letter = 5'd7;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      resetn = 1'b0;
      #1;
      checks++;
      if (obsVec() !== 39'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_check: got %h expected %h", obsVec(), 39'd0);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obsVec() !== 39'd0) begin
         errors++;
         $display("[TB] FAIL idle_after_mid_reset: got %h expected %h", obsVec(), 39'd0);
      end
   endtask

   task automatic test_new_game_priority();
      logic [29:0] nextWord = {5'd2, 5'd0, 5'd1, 5'd31, 5'd2, 5'd0};
      applyNewGame({5'd7, 5'd4, 5'd11, 5'd11, 5'd14, 5'd31});
      applyGuess(5'd11);
      resetModel(nextWord);
      word = nextWord;
      mask = maskOf();
      new_game = 1'b1;
      guess_valid = 1'b1;
      guess_letter = 5'd25;
      @(posedge clk); #1;
      new_game = 1'b0;
      guess_valid = 1'b0;
      checks++;
      if (guessed !== 26'd0 || wrong_count !== 4'd0 || guess_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL newgame_load: got guessed=%h wrong=%0d ready=%b expected 0/0/0",
                  guessed, wrong_count, guess_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (obsVec() !== expVec()) begin
         errors++;
         $display("[TB] FAIL newgame_drop_guess: got %h expected %h", obsVec(), expVec());
      end
   endtask

   task automatic test_all_blank();
      applyNewGame({6{5'd31}});
      checks++;
      if (revealed !== 6'b111111 || win_game !== 1'b0) begin
         errors++;
         $display("[TB] FAIL blank_load: got revealed=%b win=%b expected 111111/0", revealed, win_game);
      end
      applyGuess(5'd28);
      checks++;
      if (obsVec() !== expVec() || win_game !== 1'b1) begin
         errors++;
         $display("[TB] FAIL blank_win: got %h expected %h", obsVec(), expVec());
      end
   endtask

   task automatic test_random_games();
      logic [29:0] w;
      logic [4:0]  l;
      for (int g = 0; g < 10; g++) begin
         for (int i = 0; i < 6; i++)
            w[(5-i)*5 +: 5] = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
         applyNewGame(w);
         checks++;
         if (obsVec() !== expVec()) begin
            errors++;
            $display("[TB] FAIL random_load_%0d: got %h expected %h", g, obsVec(), expVec());
         end
         for (int k = 0; k < 30 && !mWin && !mLost; k++) begin
            l = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 11)) : 5'($urandom_range(0, 31));
            applyGuess(l);
            checks++;
            if (obsVec() !== expVec()) begin
               errors++;
               $display("[TB] FAIL random_g%0d_k%0d_l%0d: got %h expected %h",
                        g, k, l, obsVec(), expVec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_hello();
      test_loss();
      test_repeat_and_invalid();
      test_game_active();
      test_reset_mid_check();
      test_new_game_priority();
      test_all_blank();
      test_random_games();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
